// File: rtl/axi_burst_wr.sv
// AXI4 write-burst master: drains a prefetch FIFO into fixed-length INCR bursts walking a frame buffer.
// One burst in flight at a time; wvalid follows fifo_rd_vld, and the FIFO pops only on accepted beats.
module axi_burst_wr #(
   parameter int unsigned           ADDR_WIDTH  = 28,
   parameter int unsigned           DATA_WIDTH  = 256,
   parameter int unsigned           BURST_LEN   = 16,
   parameter int unsigned           FRAME_BEATS = 57600,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic                    fifo_rd_vld,
   input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
   output logic                    fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic                    bvalid,
   input  logic [1:0]              bresp,
   output logic                    bready,
   output logic                    frame_done,
   output logic                    wr_err,
   output logic                    busy
);

   localparam int unsigned FRAME_BURSTS = FRAME_BEATS / BURST_LEN;
   localparam int unsigned BCW          = $clog2(FRAME_BURSTS + 1);

   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
   localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
   localparam logic [BCW-1:0]        FRAME_BC    = BCW'(FRAME_BURSTS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]            rst_sync_q;
   logic                  rst_int_n;
   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            beat_q, beat_d;
   logic [BCW-1:0]        burst_q, burst_d, burst_inc;
   logic                  pend_q, pend_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  beat_acc;

   // Reset asserts immediately but is released only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign busy       = (state_q != S_IDLE);
   assign awvalid    = (state_q == S_ADDR);
   assign awaddr     = addr_q;
   assign awlen      = LAST_BEAT;
   assign wvalid     = (state_q == S_DATA) & fifo_rd_vld;
   assign wdata      = fifo_rd_data;
   assign wstrb      = '1;
   assign wlast      = (state_q == S_DATA) & (beat_q == LAST_BEAT);
   assign beat_acc   = wvalid & wready;
   assign fifo_rd_en = beat_acc;
   assign bready     = (state_q == S_RESP);
   assign frame_done = done_q;
   assign wr_err     = err_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      burst_d   = burst_q;
      pend_d    = pend_q;
      err_d     = err_q;
      done_d    = 1'b0;
      burst_inc = burst_q + BCW'(1);
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               addr_d  = BASE_ADDR;
               burst_d = '0;
            end
            if (fifo_rd_vld) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (frame_start) pend_d = 1'b1;
            if (awready) state_d = S_DATA;
         end
         S_DATA: begin
            if (frame_start) pend_d = 1'b1;
            if (beat_acc) begin
               if (wlast) begin
                  beat_d  = '0;
                  state_d = S_RESP;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: begin
            if (frame_start) pend_d = 1'b1;
            if (bvalid) begin
               state_d = S_IDLE;
               pend_d  = 1'b0;
               if (bresp != 2'b00) err_d = 1'b1;
               // A natural wrap wins over a pending restart: same address, but frame_done still fires.
               if (burst_inc == FRAME_BC) begin
                  addr_d  = BASE_ADDR;
                  burst_d = '0;
                  done_d  = 1'b1;
               end else if (pend_q || frame_start) begin
                  addr_d  = BASE_ADDR;
                  burst_d = '0;
               end else begin
                  addr_d  = addr_q + BURST_BYTES;
                  burst_d = burst_inc;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_ADDR;
         beat_q  <= '0;
         burst_q <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_axi_burst_wr.sv
// Directed bench for axi_burst_wr: two-burst frames of 16 x 256-bit beats (0x200 bytes per burst).
module tb_axi_burst_wr;

   logic         clk;
   logic         rst_n;
   logic         frame_start;
   logic         fifo_rd_vld;
   logic [255:0] fifo_rd_data;
   logic         fifo_rd_en;
   logic [27:0]  awaddr;
   logic [7:0]   awlen;
   logic         awvalid;
   logic         awready;
   logic [255:0] wdata;
   logic [31:0]  wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic         bvalid;
   logic [1:0]   bresp;
   logic         bready;
   logic         frame_done;
   logic         wr_err;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;
   int head    = 32'h1000;

   logic [27:0] obs_awaddr;
   logic [7:0]  obs_awlen;
   int          obs_pops, obs_wlast_beat, obs_bad, obs_aw_bad, obs_wv_low;
   logic        obs_done, obs_busy, obs_timeout;

   axi_burst_wr #(
      .ADDR_WIDTH (28),
      .DATA_WIDTH (256),
      .BURST_LEN  (16),
      .FRAME_BEATS(32),
      .BASE_ADDR  (28'h0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .fifo_rd_vld (fifo_rd_vld),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en  (fifo_rd_en),
      .awaddr      (awaddr),
      .awlen       (awlen),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wlast       (wlast),
      .wvalid      (wvalid),
      .wready      (wready),
      .bvalid      (bvalid),
      .bresp       (bresp),
      .bready      (bready),
      .frame_done  (frame_done),
      .wr_err      (wr_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plays FIFO + AXI slave for one burst. mode 0: no stalls, 1: awready late and wready toggling,
   // 2: FIFO empty for 5 cycles after beat 7. Inputs change on negedge, outputs sampled 1ns later.
   task automatic drive_burst(input int mode, input logic [1:0] rsp, input int fs_beat);
      int           phase, aw_cnt, drop_cnt;
      bit           tgl, prev_pop, stall_pend, fs_sent;
      logic [255:0] sv_wdata;
      logic         sv_wlast;
      obs_awaddr = '0; obs_awlen = '0; obs_pops = 0; obs_wlast_beat = 0;
      obs_bad = 0; obs_aw_bad = 0; obs_wv_low = 0; obs_timeout = 1'b0;
      phase = 0; aw_cnt = 0; drop_cnt = 0;
      tgl = 1'b0; prev_pop = 1'b0; stall_pend = 1'b0; fs_sent = 1'b0;
      sv_wdata = '0; sv_wlast = 1'b0;
      for (int c = 0; c < 300 && phase < 3; c++) begin
         @(negedge clk);
         if (prev_pop) head++;
         fifo_rd_data = {8{head}};
         fifo_rd_vld  = !(mode == 2 && obs_pops == 7 && drop_cnt < 5);
         if (!fifo_rd_vld) drop_cnt++;
         wready  = (mode == 1) ? tgl : 1'b1;
         tgl     = !tgl;
         awready = (mode != 1) || (aw_cnt >= 2);
         bvalid  = (phase == 2);
         bresp   = rsp;
         frame_start = 1'b0;
         if (fs_beat >= 0 && phase == 1 && obs_pops == fs_beat && !fs_sent) begin
            frame_start = 1'b1;
            fs_sent     = 1'b1;
         end
         #1;
         prev_pop = fifo_rd_en;
         if (fifo_rd_en !== (wvalid & wready)) obs_bad++;
         case (phase)
            0: if (awvalid) begin
                  if (aw_cnt == 0) begin
                     obs_awaddr = awaddr;
                     obs_awlen  = awlen;
                  end else if (awaddr !== obs_awaddr || awlen !== obs_awlen) begin
                     obs_aw_bad++;
                  end
                  aw_cnt++;
                  if (awready) phase = 1;
               end
            1: begin
                  if (wvalid !== fifo_rd_vld || awvalid !== 1'b0 || wstrb !== '1) obs_bad++;
                  if (!wvalid) obs_wv_low++;
                  if (stall_pend && (wdata !== sv_wdata || wlast !== sv_wlast)) obs_bad++;
                  stall_pend = 1'b0;
                  if (wvalid && !wready) begin
                     stall_pend = 1'b1;
                     sv_wdata   = wdata;
                     sv_wlast   = wlast;
                  end
                  if (wvalid && wready) begin
                     if (wdata !== {8{head}}) obs_bad++;
                     obs_pops++;
                     if (wlast) begin
                        obs_wlast_beat = obs_pops;
                        phase = 2;
                     end
                  end
               end
            default: if (bready) phase = 3;
         endcase
      end
      if (phase < 3) obs_timeout = 1'b1;
      @(negedge clk);
      if (prev_pop) head++;
      fifo_rd_vld = 1'b0; bvalid = 1'b0; frame_start = 1'b0; wready = 1'b1; awready = 1'b1;
      #1;
      obs_done = frame_done;
      obs_busy = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_start = 1'b0; fifo_rd_vld = 1'b1; fifo_rd_data = '0;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if (awvalid !== 1'b0)    begin n_fail++; $display("FAIL rst_awvalid got %b exp 0", awvalid); end
      n_tests++; if (wvalid !== 1'b0)     begin n_fail++; $display("FAIL rst_wvalid got %b exp 0", wvalid); end
      n_tests++; if (wlast !== 1'b0)      begin n_fail++; $display("FAIL rst_wlast got %b exp 0", wlast); end
      n_tests++; if (bready !== 1'b0)     begin n_fail++; $display("FAIL rst_bready got %b exp 0", bready); end
      n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_rd_en got %b exp 0", fifo_rd_en); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
      n_tests++; if (wr_err !== 1'b0)     begin n_fail++; $display("FAIL rst_wr_err got %b exp 0", wr_err); end
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_tests++; if (awaddr !== 28'h0)    begin n_fail++; $display("FAIL rst_awaddr got %h exp 0", awaddr); end
      @(negedge clk);
      fifo_rd_vld = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_basic();
      drive_burst(0, 2'b00, -1);
      n_tests++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b exp 0", obs_timeout); end
      n_tests++; if (obs_awaddr !== 28'h0) begin n_fail++; $display("FAIL basic_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_awlen !== 8'd15)  begin n_fail++; $display("FAIL basic_awlen got %0d exp 15", obs_awlen); end
      n_tests++; if (obs_pops != 16)       begin n_fail++; $display("FAIL basic_pops got %0d exp 16", obs_pops); end
      n_tests++; if (obs_wlast_beat != 16) begin n_fail++; $display("FAIL basic_wlast_beat got %0d exp 16", obs_wlast_beat); end
      n_tests++; if (obs_bad != 0 || obs_wv_low != 0) begin n_fail++; $display("FAIL basic_beats bad %0d wv_low %0d exp 0 0", obs_bad, obs_wv_low); end
      n_tests++; if (obs_done !== 1'b0)    begin n_fail++; $display("FAIL basic_frame_done got %b exp 0", obs_done); end
      n_tests++; if (obs_busy !== 1'b0)    begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", obs_busy); end
   endtask

   task automatic test_wready_toggle();
      drive_burst(1, 2'b00, -1);
      n_tests++; if (obs_timeout !== 1'b0)   begin n_fail++; $display("FAIL tgl_timeout got %b exp 0", obs_timeout); end
      n_tests++; if (obs_awaddr !== 28'h200) begin n_fail++; $display("FAIL tgl_awaddr got %h exp 200", obs_awaddr); end
      n_tests++; if (obs_aw_bad != 0)        begin n_fail++; $display("FAIL tgl_aw_hold got %0d changes exp 0", obs_aw_bad); end
      n_tests++; if (obs_pops != 16)         begin n_fail++; $display("FAIL tgl_pops got %0d exp 16", obs_pops); end
      n_tests++; if (obs_wlast_beat != 16)   begin n_fail++; $display("FAIL tgl_wlast_beat got %0d exp 16", obs_wlast_beat); end
      n_tests++; if (obs_bad != 0)           begin n_fail++; $display("FAIL tgl_stall_stable got %0d errors exp 0", obs_bad); end
      n_tests++; if (obs_done !== 1'b1)      begin n_fail++; $display("FAIL tgl_frame_done got %b exp 1", obs_done); end
   endtask

   task automatic test_fifo_stall();
      drive_burst(2, 2'b00, -1);
      n_tests++; if (obs_awaddr !== 28'h0) begin n_fail++; $display("FAIL stall_wrap_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_wv_low != 5)      begin n_fail++; $display("FAIL stall_wvalid_low got %0d exp 5", obs_wv_low); end
      n_tests++; if (obs_pops != 16)       begin n_fail++; $display("FAIL stall_pops got %0d exp 16", obs_pops); end
      n_tests++; if (obs_wlast_beat != 16) begin n_fail++; $display("FAIL stall_wlast_beat got %0d exp 16", obs_wlast_beat); end
      n_tests++; if (obs_bad != 0)         begin n_fail++; $display("FAIL stall_beats got %0d errors exp 0", obs_bad); end
      n_tests++; if (obs_done !== 1'b0)    begin n_fail++; $display("FAIL stall_frame_done got %b exp 0", obs_done); end
   endtask

   task automatic test_frame_start();
      // frame_start coinciding with the natural wrap
      drive_burst(0, 2'b00, 3);
      n_tests++; if (obs_awaddr !== 28'h200) begin n_fail++; $display("FAIL fs_wrap_awaddr got %h exp 200", obs_awaddr); end
      n_tests++; if (obs_done !== 1'b1)      begin n_fail++; $display("FAIL fs_wrap_done got %b exp 1", obs_done); end
      // frame_start mid-frame: burst completes, restart without frame_done
      drive_burst(0, 2'b00, 5);
      n_tests++; if (obs_awaddr !== 28'h0)   begin n_fail++; $display("FAIL fs_mid_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_pops != 16)         begin n_fail++; $display("FAIL fs_mid_pops got %0d exp 16", obs_pops); end
      n_tests++; if (obs_done !== 1'b0)      begin n_fail++; $display("FAIL fs_mid_done got %b exp 0", obs_done); end
      drive_burst(0, 2'b00, -1);
      n_tests++; if (obs_awaddr !== 28'h0)   begin n_fail++; $display("FAIL fs_reload_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_done !== 1'b0)      begin n_fail++; $display("FAIL fs_reload_done got %b exp 0", obs_done); end
   endtask

   task automatic test_idle_frame_start();
      n_tests++; if (awaddr !== 28'h200) begin n_fail++; $display("FAIL idle_pre_awaddr got %h exp 200", awaddr); end
      @(negedge clk);
      frame_start = 1'b1;
      #1;
      n_tests++; if (awaddr !== 28'h200) begin n_fail++; $display("FAIL idle_same_cycle_awaddr got %h exp 200", awaddr); end
      @(negedge clk);
      frame_start = 1'b0;
      #1;
      n_tests++; if (awaddr !== 28'h0)   begin n_fail++; $display("FAIL idle_reload_awaddr got %h exp 0", awaddr); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
      drive_burst(0, 2'b00, -1);
      n_tests++; if (obs_awaddr !== 28'h0) begin n_fail++; $display("FAIL idle_burst_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_done !== 1'b0)    begin n_fail++; $display("FAIL idle_burst_done got %b exp 0", obs_done); end
   endtask

   task automatic test_error_and_reset();
      n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL err_before got %b exp 0", wr_err); end
      drive_burst(0, 2'b10, -1);
      n_tests++; if (obs_awaddr !== 28'h200) begin n_fail++; $display("FAIL err_awaddr got %h exp 200", obs_awaddr); end
      n_tests++; if (wr_err !== 1'b1)        begin n_fail++; $display("FAIL err_set got %b exp 1", wr_err); end
      n_tests++; if (obs_done !== 1'b1)      begin n_fail++; $display("FAIL err_frame_done got %b exp 1", obs_done); end
      drive_burst(0, 2'b00, -1);
      n_tests++; if (wr_err !== 1'b1)        begin n_fail++; $display("FAIL err_sticky got %b exp 1", wr_err); end
      // start a burst at 0x200 and kill it with reset mid-data
      @(negedge clk);
      fifo_rd_vld = 1'b1; fifo_rd_data = {8{head}}; awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (busy !== 1'b1 || wvalid !== 1'b1) begin n_fail++; $display("FAIL mid_burst busy %b wvalid %b exp 1 1", busy, wvalid); end
      n_tests++; if (awaddr !== 28'h200) begin n_fail++; $display("FAIL mid_burst_awaddr got %h exp 200", awaddr); end
      n_tests++; if (wr_err !== 1'b1)    begin n_fail++; $display("FAIL mid_burst_wr_err got %b exp 1", wr_err); end
      rst_n = 1'b0;
      #1;
      n_tests++; if ({awvalid, wvalid, wlast, bready, fifo_rd_en, frame_done, wr_err, busy} !== 8'h00)
         begin n_fail++; $display("FAIL abort_outputs got %b exp 00000000", {awvalid, wvalid, wlast, bready, fifo_rd_en, frame_done, wr_err, busy}); end
      n_tests++; if (awaddr !== 28'h0)   begin n_fail++; $display("FAIL abort_awaddr got %h exp 0", awaddr); end
      @(negedge clk);
      fifo_rd_vld = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      drive_burst(0, 2'b00, -1);
      n_tests++; if (obs_awaddr !== 28'h0) begin n_fail++; $display("FAIL restart_awaddr got %h exp 0", obs_awaddr); end
      n_tests++; if (obs_pops != 16 || obs_wlast_beat != 16)
         begin n_fail++; $display("FAIL restart_beats pops %0d wlast %0d exp 16 16", obs_pops, obs_wlast_beat); end
      n_tests++; if (wr_err !== 1'b0)      begin n_fail++; $display("FAIL restart_wr_err got %b exp 0", wr_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wready_toggle();
      test_fifo_stall();
      test_frame_start();
      test_idle_frame_start();
      test_error_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
